// File: rtl/ysyx_22041752_icache_req_stage_pkg.sv
// ysyx_22041752_icache_req_stage_pkg: shared I-cache defaults, FSM encoding and bus-width helper
package ysyx_22041752_icache_req_stage_pkg;
  localparam int ADDR_W_D = 32;
  localparam int OFFSET_W_D = 4;
  localparam int INDEX_W_D = 7;
  localparam int WAYS_D = 2;
  localparam int BANK_W_D = 1;
  localparam int RADDR_W_D = INDEX_W_D - BANK_W_D;
  typedef enum logic {RUN = 1'b0, LOCK = 1'b1} state_e;
  function automatic int rden_w(input int ways, input int bank_w);
    return ways << bank_w;
  endfunction
endpackage

// File: rtl/ysyx_22041752_icache_bank_dec.sv
// ysyx_22041752_icache_bank_dec: index -> one-hot bank, SRAM row address and active-low per-way/bank read enables
module ysyx_22041752_icache_bank_dec import ysyx_22041752_icache_req_stage_pkg::*; #(
  parameter int INDEX_W = INDEX_W_D,
  parameter int WAYS = WAYS_D,
  parameter int BANK_W = BANK_W_D
) (
  input  logic [INDEX_W-1:0] index,
  input  logic fire,
  output logic [rden_w(WAYS, BANK_W)-1:0] rden_n,
  output logic [(1<<BANK_W)-1:0] bank_oh,
  output logic [INDEX_W-BANK_W-1:0] raddr
);
  localparam int BANKS = 1 << BANK_W;
  logic [BANK_W-1:0] bank;
  assign bank = index[INDEX_W-1 -: BANK_W];
  assign bank_oh = BANKS'(1) << bank;
  assign raddr = index[INDEX_W-BANK_W-1:0];
  assign rden_n = ~({WAYS{bank_oh}} & {rden_w(WAYS, BANK_W){fire}});
endmodule

// File: rtl/ysyx_22041752_icache_req_stage.sv
// ysyx_22041752_icache_req_stage: fetch-request handshake, SRAM read issue and compare-stage register with refill lockout
module ysyx_22041752_icache_req_stage import ysyx_22041752_icache_req_stage_pkg::*; #(
  parameter int ADDR_W = ADDR_W_D,
  parameter int OFFSET_W = OFFSET_W_D,
  parameter int INDEX_W = INDEX_W_D,
  parameter int WAYS = WAYS_D,
  parameter int BANK_W = BANK_W_D
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic req_ready,
  input  logic flush,
  input  logic refill_start,
  input  logic refill_done,
  input  logic cs_allowin,
  output logic cs_valid,
  output logic [ADDR_W-1:0] cs_addr,
  output logic [(1<<BANK_W)-1:0] cs_bank_oh,
  output logic [rden_w(WAYS, BANK_W)-1:0] rden_n,
  output logic [INDEX_W-BANK_W-1:0] raddr
);
  localparam int BANKS = 1 << BANK_W;
  state_e state_q, state_d;
  logic cs_valid_q;
  logic [ADDR_W-1:0] cs_addr_q;
  logic [BANKS-1:0] cs_bank_oh_q, bank_oh;
  logic fire;
  always_comb state_d = refill_done ? RUN : refill_start ? LOCK : state_q;
  assign req_ready = !reset && state_q == RUN && !refill_start && !flush && (!cs_valid_q || cs_allowin);
  assign fire = req_valid && req_ready;
  ysyx_22041752_icache_bank_dec #(.INDEX_W(INDEX_W), .WAYS(WAYS), .BANK_W(BANK_W)) u_dec (
    .index(req_addr[OFFSET_W+INDEX_W-1:OFFSET_W]),
    .fire(fire),
    .rden_n(rden_n),
    .bank_oh(bank_oh),
    .raddr(raddr)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cs_valid_q <= 1'b0;
      cs_addr_q <= '0;
      cs_bank_oh_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush) cs_valid_q <= 1'b0;
      else if (fire) begin
        cs_valid_q <= 1'b1;
        cs_addr_q <= req_addr;
        cs_bank_oh_q <= bank_oh;
      end else if (cs_allowin) cs_valid_q <= 1'b0;
    end
  end
  assign cs_valid = cs_valid_q;
  assign cs_addr = cs_addr_q;
  assign cs_bank_oh = cs_bank_oh_q;
endmodule

// File: tb/tb_ysyx_22041752_icache_req_stage.sv
// tb_ysyx_22041752_icache_req_stage: checks a 2-way/2-bank and a 4-way/4-bank instance against a behavioural model
module tb_ysyx_22041752_icache_req_stage;
  logic clk = 0, reset = 1, req_valid = 0, flush = 0, refill_start = 0, refill_done = 0, cs_allowin = 1;
  logic [31:0] req_addr = '0;
  logic ready_a, ready_b, csv_a, csv_b;
  logic [31:0] csa_a, csa_b;
  logic [1:0] boh_a;
  logic [3:0] boh_b, rden_a;
  logic [15:0] rden_b;
  logic [5:0] raddr_a;
  logic [4:0] raddr_b;
  int tests = 0, fails = 0;
  bit started = 0, lock_m = 0, csv_m = 0, loaded_m = 0;
  logic [31:0] csa_m = '0;
  always #5 clk = ~clk;
  ysyx_22041752_icache_req_stage dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_ready(ready_a),
    .flush(flush), .refill_start(refill_start), .refill_done(refill_done), .cs_allowin(cs_allowin),
    .cs_valid(csv_a), .cs_addr(csa_a), .cs_bank_oh(boh_a), .rden_n(rden_a), .raddr(raddr_a)
  );
  ysyx_22041752_icache_req_stage #(.WAYS(4), .BANK_W(2)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_ready(ready_b),
    .flush(flush), .refill_start(refill_start), .refill_done(refill_done), .cs_allowin(cs_allowin),
    .cs_valid(csv_b), .cs_addr(csa_b), .cs_bank_oh(boh_b), .rden_n(rden_b), .raddr(raddr_b)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask
  function automatic int idx_of(input logic [31:0] a);
    return int'(a[10:4]);
  endfunction
  function automatic int bank_of(input logic [31:0] a, input int bw);
    return idx_of(a) / (128 >> bw);
  endfunction
  function automatic bit ready_exp();
    return !reset && !lock_m && !refill_start && !flush && (!csv_m || cs_allowin);
  endfunction
  function automatic logic [15:0] rden_exp(input int ways, input int bw, input logic [31:0] a, input bit f);
    logic [15:0] r;
    r = '1;
    for (int w = 0; w < ways; w++)
      for (int b = 0; b < (1 << bw); b++)
        if (f && b == bank_of(a, bw)) r[w*(1<<bw)+b] = 1'b0;
    if (ways * (1 << bw) < 16) r = r & ((16'd1 << (ways * (1 << bw))) - 16'd1);
    return r;
  endfunction
  function automatic logic [3:0] boh_exp(input int bw);
    return loaded_m ? 4'(1 << bank_of(csa_m, bw)) : 4'd0;
  endfunction
  always @(negedge clk) if (started) begin
    bit f;
    f = req_valid && ready_exp();
    chk("ready_a", 64'(ready_a), 64'(ready_exp()));
    chk("ready_b", 64'(ready_b), 64'(ready_exp()));
    chk("cs_valid_a", 64'(csv_a), 64'(csv_m));
    chk("cs_valid_b", 64'(csv_b), 64'(csv_m));
    chk("cs_addr_a", 64'(csa_a), 64'(csa_m));
    chk("cs_addr_b", 64'(csa_b), 64'(csa_m));
    chk("cs_bank_oh_a", 64'(boh_a), 64'(boh_exp(1)));
    chk("cs_bank_oh_b", 64'(boh_b), 64'(boh_exp(2)));
    chk("rden_n_a", 64'(rden_a), 64'(rden_exp(2, 1, req_addr, f)));
    chk("rden_n_b", 64'(rden_b), 64'(rden_exp(4, 2, req_addr, f)));
    chk("raddr_a", 64'(raddr_a), 64'(idx_of(req_addr) % 64));
    chk("raddr_b", 64'(raddr_b), 64'(idx_of(req_addr) % 32));
  end
  always @(posedge clk) begin
    bit f;
    started <= 1;
    f = req_valid && ready_exp();
    if (reset) begin
      lock_m <= 0;
      csv_m <= 0;
      csa_m <= '0;
      loaded_m <= 0;
    end else begin
      lock_m <= refill_done ? 1'b0 : refill_start ? 1'b1 : lock_m;
      if (flush) csv_m <= 0;
      else if (f) begin
        csv_m <= 1;
        csa_m <= req_addr;
        loaded_m <= 1;
      end else if (cs_allowin) csv_m <= 0;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic [31:0] addrs [16] = '{32'h8000_0000, 32'h8000_0410, 32'h8000_0210, 32'h8000_0614,
                              32'h8000_07F0, 32'h8000_0003, 32'h1234_5678, 32'hFFFF_FFFF,
                              32'h8000_0200, 32'h8000_0400, 32'h8000_0600, 32'h0000_0010,
                              32'h8000_03F0, 32'h8000_05F8, 32'hDEAD_BEEF, 32'h8000_0100};
  initial begin
    repeat (2) tick();
    #2;
    chk("lit_reset_ready", 64'(ready_a), 64'h0);
    chk("lit_reset_rden", 64'(rden_a), 64'hF);
    tick();
    reset = 0; req_valid = 1; req_addr = 32'h8000_0010; cs_allowin = 1;
    #2;
    chk("lit_fire0_ready", 64'(ready_a), 64'h1);
    chk("lit_fire0_rden_a", 64'(rden_a), 64'hA);
    chk("lit_fire0_rden_b", 64'(rden_b), 64'hEEEE);
    chk("lit_fire0_raddr", 64'(raddr_a), 64'h1);
    tick();
    req_addr = 32'h8000_0410;
    #2;
    chk("lit_cs_valid", 64'(csv_a), 64'h1);
    chk("lit_cs_addr", 64'(csa_a), 64'h8000_0010);
    chk("lit_cs_bank_oh", 64'(boh_a), 64'h1);
    chk("lit_fire1_rden_a", 64'(rden_a), 64'h5);
    chk("lit_fire1_rden_b", 64'(rden_b), 64'hBBBB);
    chk("lit_fire1_raddr", 64'(raddr_a), 64'h1);
    tick();
    cs_allowin = 0; req_addr = 32'h8000_0030;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("lit_hold_ready", 64'(ready_a), 64'h0);
      chk("lit_hold_rden", 64'(rden_b), 64'hFFFF);
      tick();
    end
    cs_allowin = 1;
    #2;
    chk("lit_hold_addr", 64'(csa_a), 64'h8000_0410);
    chk("lit_hold_bank_b", 64'(boh_b), 64'h4);
    chk("lit_release_ready", 64'(ready_a), 64'h1);
    tick();
    refill_start = 1; req_addr = 32'h8000_0040;
    #2 chk("lit_rs_ready", 64'(ready_a), 64'h0);
    tick();
    refill_start = 0;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk("lit_lock_ready", 64'(ready_b), 64'h0);
      chk("lit_lock_rden", 64'(rden_a), 64'hF);
      tick();
    end
    refill_done = 1;
    #2 chk("lit_rd_ready", 64'(ready_a), 64'h0);
    tick();
    refill_done = 0;
    #2 chk("lit_after_rd_ready", 64'(ready_a), 64'h1);
    tick();
    flush = 1;
    #2;
    chk("lit_flush_csv_before", 64'(csv_a), 64'h1);
    chk("lit_flush_ready", 64'(ready_a), 64'h0);
    chk("lit_flush_rden", 64'(rden_a), 64'hF);
    tick();
    flush = 0; req_valid = 0;
    #2 chk("lit_flush_csv", 64'(csv_a), 64'h0);
    tick();
    refill_start = 1; refill_done = 1;
    tick();
    refill_start = 0; refill_done = 0; req_valid = 1; req_addr = 32'h8000_0650;
    #2 chk("lit_both_run", 64'(ready_a), 64'h1);
    tick();
    req_valid = 0; refill_start = 1;
    tick();
    refill_start = 0; req_valid = 1;
    #2 chk("lit_locked", 64'(ready_b), 64'h0);
    tick();
    reset = 1;
    tick();
    reset = 0;
    #2;
    chk("lit_post_reset_csv", 64'(csv_b), 64'h0);
    chk("lit_post_reset_ready", 64'(ready_b), 64'h1);
    for (int i = 0; i < 16; i++) begin
      tick();
      req_addr = addrs[i];
      req_valid = (i % 4) != 3;
      cs_allowin = (i % 3) != 0;
      flush = i == 5;
      refill_start = i == 9;
      refill_done = i == 12;
    end
    tick();
    req_valid = 0; flush = 0; refill_start = 0; refill_done = 0; cs_allowin = 1;
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
